// File: rtl/rr_arb_mux.sv
// N-channel arbiter feeding a single registered output slot.
// Round-robin or fixed-priority selection, one word per cycle under no backpressure.
module rr_arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    localparam int CW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    input  logic                 fixed_pri,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready
);

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [CW-1:0]    ch_p1;
    logic [CW-1:0]    last_ch;

    logic             load_en;
    logic             found;
    logic [CW-1:0]    win_ch;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] win_data;

    assign load_en = !vld_p1 | out_ready;

    // Stage p0: pick a winner. Round-robin searches from last_ch+1 upward; the
    // k=NCH step wraps back onto last_ch itself, so a lone requester always wins.
    always_comb begin
        found  = 1'b0;
        win_ch = '0;
        idx    = '0;
        if (fixed_pri) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && in_valid[i]) begin
                    found  = 1'b1;
                    win_ch = CW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                idx = last_ch + CW'(k);
                if (!found && in_valid[idx]) begin
                    found  = 1'b1;
                    win_ch = idx;
                end
            end
        end
    end

    assign win_data = in_data[win_ch*WIDTH +: WIDTH];

    // rst_n gates the grant so no channel is acknowledged while reset is held.
    assign in_ready = (rst_n && load_en && found) ? (NCH'(1) << win_ch) : '0;

    // Stage p1: output slot and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            last_ch <= CW'(NCH-1);
        end else if (load_en) begin
            vld_p1 <= found;
            if (found) begin
                data_p1 <= win_data;
                ch_p1   <= win_ch;
                if (!fixed_pri)
                    last_ch <= win_ch;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux at NCH=4, WIDTH=32: vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int CW    = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 fixed_pri;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fixed_pri (fixed_pri),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] iv;
        logic       fp;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t        vecs[20];
    logic [31:0] chan_word[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pack_data();
        for (int i = 0; i < NCH; i++)
            in_data[i*WIDTH +: WIDTH] = chan_word[i];
    endtask

    initial begin
        chan_word[0] = 32'hA0A0_0000;
        chan_word[1] = 32'hA0A0_1111;
        chan_word[2] = 32'hA0A0_2222;
        chan_word[3] = 32'hA0A0_3333;

        //           iv       fp    ordy  rdy      ov    ch
        vecs[0]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[7]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[8]  = '{4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[9]  = '{4'b1010, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[10] = '{4'b1010, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[11] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[12] = '{4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[13] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[14] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1};
        vecs[15] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[17] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
        vecs[18] = '{4'b0101, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[19] = '{4'b0101, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};

        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        fixed_pri = 1'b0;
        out_ready = 1'b1;
        pack_data();

        #3;
        chk("reset_in_ready",  64'(in_ready),  64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data",  64'(out_data),  64'd0);
        chk("reset_out_ch",    64'(out_ch),    64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 20; v++) begin
            if (v != 0) @(negedge clk);
            in_valid  = vecs[v].iv;
            fixed_pri = vecs[v].fp;
            out_ready = vecs[v].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'(vecs[v].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'(vecs[v].exp_ov));
            chk($sformatf("v%0d_out_ch", v),    64'(out_ch),    64'(vecs[v].exp_ch));
            chk($sformatf("v%0d_out_data", v),  64'(out_data),  64'(chan_word[vecs[v].exp_ch]));
        end

        // Backpressure: load 0x1234_5678 from channel 3 (pointer is at 2), then stall.
        @(negedge clk);
        chan_word[3] = 32'h1234_5678;
        pack_data();
        in_valid  = 4'b1000;
        fixed_pri = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_load_ch",   64'(out_ch),   64'd3);
        chk("bp_load_data", 64'(out_data), 64'h1234_5678);
        chan_word[3] = 32'hA0A0_3333;
        pack_data();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid  = 4'b1111;
            out_ready = 1'b0;
            #1;
            chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d_out_data", c),  64'(out_data),  64'h1234_5678);
            chk($sformatf("bp%0d_out_ch", c),    64'(out_ch),    64'd3);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'b0001);
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 64'(out_valid), 64'd1);
        chk("bp_release_out_ch",    64'(out_ch),    64'd0);
        chk("bp_release_out_data",  64'(out_data),  64'(chan_word[0]));

        // Mid-operation reset with a held word.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_data",  64'(out_data),  64'd0);
        chk("mrst_out_ch",    64'(out_ch),    64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk);
        #1;
        chk("mrst_edge_in_ready",  64'(in_ready),  64'd0);
        chk("mrst_edge_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        #1;
        chk("mrst_rel_in_ready", 64'(in_ready), 64'b1000);
        @(posedge clk);
        #1;
        chk("mrst_rel_out_valid", 64'(out_valid), 64'd1);
        chk("mrst_rel_out_ch",    64'(out_ch),    64'd3);
        chk("mrst_rel_out_data",  64'(out_data),  64'(chan_word[3]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
